// File: rtl/tt_um_counter_modal.sv
// Modal up/down counter with a programmable limit, wrap/saturate modes and a terminal-count pulse.
// Optional clock-enable prescaler (divide by 1/2/4/8) is built when COUNTER_PRESCALE_EN is defined.
module tt_um_counter_modal #(
  parameter int WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             en;
  logic             dir;
  logic             load;
  logic             mode;
  logic             clear;
  logic             load_limit;
  logic [WIDTH-1:0] data;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  logic             tc;
  logic             tick;

  logic [WIDTH:0]   step_res;
  logic [6:0]       count_ext;
  logic             unused_bits;

  assign en         = ui_in[0];
  assign dir        = ui_in[1];
  assign load       = ui_in[2];
  assign mode       = ui_in[3];
  assign clear      = ui_in[4];
  assign load_limit = ui_in[5];
  assign data       = uio_in[WIDTH-1:0];

  // Returns {boundary_hit, next_count}; a boundary step raises tc in either mode.
  function automatic logic [WIDTH:0] step_fn(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] lim,
    input logic             up,
    input logic             sat
  );
    logic [WIDTH:0] r;
    if (up) begin
      if (cur < lim) r = {1'b0, cur + ONE};
      else           r = {1'b1, (sat ? lim : ZERO)};
    end else begin
      if (cur != ZERO) r = {1'b0, cur - ONE};
      else             r = {1'b1, (sat ? ZERO : lim)};
    end
    return r;
  endfunction

  assign step_res = step_fn(count, limit, dir, mode);

`ifdef COUNTER_PRESCALE_EN
  logic [2:0] presc;
  logic [2:0] presc_max;

  always_comb begin
    presc_max = 3'd0;
    case (ui_in[7:6])
      2'd0:    presc_max = 3'd0;
      2'd1:    presc_max = 3'd1;
      2'd2:    presc_max = 3'd3;
      default: presc_max = 3'd7;
    endcase
  end

  assign tick = (presc == presc_max);

  // Prescaler only advances while counting is enabled; clear/load restart the divide phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= 3'd0;
    end else if (ena) begin
      if (clear || load) presc <= 3'd0;
      else if (en)       presc <= tick ? 3'd0 : presc + 3'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Limit updates alongside any count action; a same-edge step still uses the old limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      limit <= '1;
      tc    <= 1'b0;
    end else if (ena) begin
      if (load_limit) limit <= data;
      if (clear) begin
        count <= '0;
        tc    <= 1'b0;
      end else if (load) begin
        count <= data;
        tc    <= 1'b0;
      end else if (en && tick) begin
        count <= step_res[WIDTH-1:0];
        tc    <= step_res[WIDTH];
      end else begin
        tc    <= 1'b0;
      end
    end
  end

  assign count_ext   = 7'(count);
  assign uo_out      = {tc, count_ext};
  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign unused_bits = &{1'b0, ui_in[7:6], uio_in};

endmodule

// File: doc/tt_um_counter_modal.md
TT_UM_COUNTER_MODAL -- requirements
Module: tt_um_counter_modal

Interface
REQ-001 Parameter: WIDTH, default 7, counter width in bits; legal range 1..7.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: ena  input  1  design enable; low freezes all state.
REQ-005 Port: ui_in  input  8  control: [0] en, [1] dir (1=up, 0=down), [2] load, [3] mode (0=wrap, 1=saturate), [4] clear, [5] load_limit, [7:6] prescale select.
REQ-006 Port: uio_in  input  8  data; [WIDTH-1:0] is the load value and the limit value; upper bits ignored.
REQ-007 Port: uo_out  output  8  [WIDTH-1:0] count, [6:WIDTH] zero, [7] tc (terminal-count pulse).
REQ-008 Port: uio_out  output  8  constant 0.
REQ-009 Port: uio_oe  output  8  constant 0; all uio pins are inputs.

Function
REQ-010 State: count (WIDTH bits), limit (WIDTH bits), tc (1 bit), prescaler counter (3 bits, only with REQ-024).
REQ-011 With ena=0, no state register changes; outputs hold.
REQ-012 Priority with ena=1: clear > load > step; load_limit is independent and may coincide with any of them.
REQ-013 clear=1: count=0, prescaler=0, tc=0 on the next edge.
REQ-014 load=1 (clear=0): count=uio_in[WIDTH-1:0], prescaler=0, tc=0 on the next edge; count is NOT clamped to limit.
REQ-015 load_limit=1: limit=uio_in[WIDTH-1:0] on the next edge; new limit governs steps from the following cycle.
REQ-016 Step occurs on an edge where ena=1, en=1, clear=0, load=0 and tick=1 (REQ-024/025); count is visible on uo_out one cycle after the step edge.
REQ-017 Up step: count<limit -> count+1; count>=limit -> wrap mode: 0, saturate mode: hold count at limit (count>limit is forced to limit).
REQ-018 Down step: count>0 -> count-1; count==0 -> wrap mode: limit, saturate mode: hold 0.
REQ-019 tc is registered: 1 for exactly the cycle after a step taken at a boundary (up with count>=limit, or down with count==0), in both modes; otherwise 0.
REQ-020 Continuous stepping at a boundary in saturate mode produces tc=1 on every step cycle.
REQ-021 limit=0: up step always yields 0 and tc=1; down step at 0 yields 0 and tc=1.
REQ-022 dir and mode may change any cycle; the value sampled on the step edge applies.

Reset
REQ-023 On a rising edge with rst_n=0 (regardless of ena or ui_in): count=0, limit=all ones (2^WIDTH-1), tc=0, prescaler=0; uo_out=8'h00 the following cycle; reset mid-count discards all progress.

Configuration
REQ-024 Macro COUNTER_PRESCALE_EN defined: tick=1 when prescaler==(2^sel-1), sel=ui_in[7:6] (divide by 1, 2, 4, 8); prescaler increments on every edge with ena=1 and en=1, clears to 0 on tick, clear, load or reset; prescaler holds when en=0.
REQ-025 Macro COUNTER_PRESCALE_EN undefined: no prescaler register; tick=1 constantly; ui_in[7:6] ignored.

Verification
REQ-026 Reset then en=1, dir=1, wrap, sel=0, limit default 127, run 130 cycles -> count 0,1..127,0,1; tc=1 only in the cycle count shows 0 after 127.
REQ-027 load_limit with uio_in=5, saturate, up 10 steps -> count stops at 5; tc=1 on each step cycle after count reaches 5.
REQ-028 load with uio_in=3, dir=0, wrap, limit=5 -> count 2,1,0,5,4; tc=1 in the cycle count shows 5.
REQ-029 clear and load asserted together with uio_in=9 -> count=0; ena=0 for 5 cycles with en=1 -> count unchanged.
REQ-030 COUNTER_PRESCALE_EN defined, sel=2'b10, up from 0 -> count increments once every 4 cycles; undefined build with same stimulus -> increments every cycle.
REQ-031 rst_n=0 for one edge at count=40, limit=20 -> next cycle uo_out=8'h00, limit=127.
